multi_bank_mem: RTL and testbench
=================================

MULTI_BANK_MEM -- requirements
Module: multi_bank_mem

Interface
REQ-001 Parameter DATA_W, 8, data word width in bits.
REQ-002 Parameter ADDR_W, 8, word address width; DEPTH = 2**ADDR_W words per bank.
REQ-003 Parameter NUM_BANKS, 16, number of independent banks.
REQ-004 Parameter BANK_W, 4, bank select width; SHALL satisfy 2**BANK_W >= NUM_BANKS.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Clk  input  1  rising-edge clock for all state.
REQ-007 Rst  input  1  synchronous, active-high reset.
REQ-008 Bank  input  BANK_W  bank select for read and write.
REQ-009 Address  input  ADDR_W  word index within the bank.
REQ-010 WriteData  input  DATA_W  write data.
REQ-011 MemWrite  input  1  write request, sampled at rising Clk.
REQ-012 MemRead  input  1  read request, sampled at rising Clk.
REQ-013 Broadcast  input  1  when high with MemWrite, write all banks at Address and ignore Bank.
REQ-014 ReadData  output  DATA_W  registered read data.
REQ-015 ReadValid  output  1  high for one cycle when ReadData holds the result of a read.
REQ-016 Busy  output  1  high while the clear sequence runs; requests are ignored.
REQ-017 BankErr  output  1  high for one cycle after a non-broadcast access to Bank >= NUM_BANKS.

Function
REQ-018 The FSM SHALL have two states: CLEAR and READY.
REQ-019 CLEAR: a counter SHALL step from 0 to DEPTH-1, writing zero to that word in every bank, one word per cycle, so the sequence lasts DEPTH cycles.
REQ-020 CLEAR SHALL move to READY on the cycle after the counter writes DEPTH-1; Busy SHALL fall on the same edge.
REQ-021 While Busy is high, MemWrite, MemRead and Broadcast SHALL be ignored; ReadValid and BankErr SHALL stay 0.
REQ-022 READY write: MemWrite=1 at an edge SHALL update mem[Bank][Address] at that edge.
REQ-023 READY broadcast write: MemWrite=1 with Broadcast=1 SHALL update Address in all NUM_BANKS banks at that edge.
REQ-024 READY read: MemRead=1 at edge N SHALL present mem[Bank][Address] on ReadData after edge N, with ReadValid=1; read latency is 1 cycle.
REQ-025 With no read at an edge, ReadData SHALL go to 0 and ReadValid to 0 after that edge.
REQ-026 Read and write to the same bank and address at the same edge SHALL return the old data (read-before-write); the new data is visible to the next read.
REQ-027 Read and write to different locations at the same edge SHALL both complete.
REQ-028 Bank >= NUM_BANKS on a non-broadcast access: the write SHALL be discarded; a read SHALL return ReadData=0 with ReadValid=1; BankErr SHALL be 1 for one cycle.
REQ-029 Address SHALL cover the full range 0..DEPTH-1, with no wrap or aliasing between banks.

Reset
REQ-030 Rst=1 at an edge SHALL set: state CLEAR, counter 0, Busy 1, ReadData 0, ReadValid 0, BankErr 0.
REQ-031 Rst asserted during CLEAR or READY SHALL restart the clear from address 0, discarding any request in the same cycle.
REQ-032 Array contents are undefined until the first clear sequence completes.

Structure
REQ-033 Package multi_mem_pkg SHALL hold the default DATA_W, ADDR_W, NUM_BANKS and BANK_W, and the FSM state type {CLEAR, READY}.
REQ-034 Sub-module mem_bank SHALL implement one DATA_W x DEPTH bank: one synchronous write port and one registered read port with read-before-write.
REQ-035 multi_bank_mem SHALL instantiate NUM_BANKS mem_bank copies via generate and hold the FSM, clear counter, bank decode and output mux.

Verification
REQ-036 Clear: Rst 1 cycle, then wait; Busy high for exactly 256 cycles, after which reads of banks 0, 7 and 15 at addresses 0x00 and 0xFF each return 0x00 with ReadValid=1.
REQ-037 Write/read: write 0xA5 to bank 3, address 0x10; read bank 3, address 0x10 -> 0xA5 one cycle later; read bank 4, address 0x10 -> 0x00.
REQ-038 Collision: bank 3, address 0x10 holds 0xA5; at one edge write 0x3C there and read it -> 0xA5; next read -> 0x3C.
REQ-039 Broadcast: write 0x77 to address 0x20 with Broadcast=1; reads of address 0x20 in banks 0..15 each return 0x77.
REQ-040 Reset mid-op: assert Rst at clear count 100, and again after a write of 0x11 to bank 1, address 0x01; Busy holds 256 cycles from the last Rst, and bank 1, address 0x01 reads 0x00.
REQ-041 Bad bank (NUM_BANKS=12): write 0xFF to bank 13, then read bank 13 -> ReadData 0x00, ReadValid 1, BankErr 1; no bank is modified.

Source files
------------

// File: rtl/multi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_mem_pkg
// Description : Default geometry and FSM state type for the banked memory.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_mem_pkg;

    localparam int c_DATA_W    = 8;
    localparam int c_ADDR_W    = 8;
    localparam int c_NUM_BANKS = 16;
    localparam int c_BANK_W    = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : mem_bank
// Description : One DATA_W x 2**ADDR_W bank, sync write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bank
    import multi_mem_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata_q;

    // Both updates are non-blocking, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/multi_bank_mem.sv
`default_nettype none
// ============================================================================
// Module      : multi_bank_mem
// Description : NUM_BANKS independent banks with broadcast write and clear-on-reset.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_bank_mem
    import multi_mem_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int NUM_BANKS = c_NUM_BANKS,
    parameter int BANK_W    = c_BANK_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [BANK_W-1:0] Bank,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              Broadcast,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    output logic              Busy,
    output logic              BankErr
);

    state_t              r_state_q, w_state_d;
    logic [ADDR_W-1:0]   r_cnt_q, w_cnt_d;
    logic                r_valid_q, w_valid_d;
    logic                r_err_q, w_err_d;
    logic [BANK_W-1:0]   r_rd_bank_q, w_rd_bank_d;

    logic                w_ready;
    logic                w_bank_ok;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;
    logic [NUM_BANKS-1:0] w_bank_we;
    logic [NUM_BANKS-1:0] w_bank_re;
    logic [DATA_W-1:0]   w_bank_rdata [NUM_BANKS];
    logic [DATA_W-1:0]   w_rdata_mux;

    assign w_ready   = (r_state_q == READY) && !Rst;
    assign w_bank_ok = {1'b0, Bank} < (BANK_W+1)'(NUM_BANKS);

    // During the clear every bank is written with zero at the counter address.
    assign w_waddr = (r_state_q == CLEAR) ? r_cnt_q : Address;
    assign w_wdata = (r_state_q == CLEAR) ? '0 : WriteData;

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_valid_d   = 1'b0;
        w_err_d     = 1'b0;
        w_rd_bank_d = r_rd_bank_q;
        if (r_state_q == CLEAR) begin
            w_cnt_d = r_cnt_q + 1'b1;
            if (r_cnt_q == '1) begin
                w_state_d = READY;
            end
        end else begin
            w_valid_d   = MemRead;
            w_rd_bank_d = Bank;
            w_err_d     = !w_bank_ok && (MemRead || (MemWrite && !Broadcast));
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state_q   <= CLEAR;
            r_cnt_q     <= '0;
            r_valid_q   <= 1'b0;
            r_err_q     <= 1'b0;
            r_rd_bank_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_valid_q   <= w_valid_d;
            r_err_q     <= w_err_d;
            r_rd_bank_q <= w_rd_bank_d;
        end
    end

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            assign w_bank_we[g] = (r_state_q == CLEAR) ||
                                  (w_ready && MemWrite && (Broadcast || (Bank == BANK_W'(g))));
            assign w_bank_re[g] = w_ready && MemRead && (Bank == BANK_W'(g));

            mem_bank #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_bank (
                .clk     (Clk),
                .i_we    (w_bank_we[g]),
                .i_waddr (w_waddr),
                .i_wdata (w_wdata),
                .i_re    (w_bank_re[g]),
                .i_raddr (Address),
                .o_rdata (w_bank_rdata[g])
            );
        end
    endgenerate

    // An out-of-range bank matches no entry, so a bad read yields zero.
    always_comb begin
        w_rdata_mux = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (r_rd_bank_q == BANK_W'(i)) begin
                w_rdata_mux = w_bank_rdata[i];
            end
        end
    end

    assign ReadData  = r_valid_q ? w_rdata_mux : '0;
    assign ReadValid = r_valid_q;
    assign BankErr   = r_err_q;
    assign Busy      = (r_state_q == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_multi_bank_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_bank_mem
// Description : Bench for multi_bank_mem; full-size and 12-bank copies share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_bank_mem;

    logic       Clk = 1'b0;
    logic       rst;
    logic [3:0] bank;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       we, re, bc;

    logic [7:0] rd_a, rd_b;
    logic       rv_a, rv_b, busy_a, busy_b, err_a, err_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 Clk = ~Clk;

    multi_bank_mem u_dut_a (
        .Clk(Clk), .Rst(rst), .Bank(bank), .Address(addr), .WriteData(wd),
        .MemWrite(we), .MemRead(re), .Broadcast(bc),
        .ReadData(rd_a), .ReadValid(rv_a), .Busy(busy_a), .BankErr(err_a)
    );

    multi_bank_mem #(.NUM_BANKS(12)) u_dut_b (
        .Clk(Clk), .Rst(rst), .Bank(bank), .Address(addr), .WriteData(wd),
        .MemWrite(we), .MemRead(re), .Broadcast(bc),
        .ReadData(rd_b), .ReadValid(rv_b), .Busy(busy_b), .BankErr(err_b)
    );

    // Reference model: plain arrays plus a remaining-clear-cycles count.
    logic [7:0] m_mem [2][16][256];
    int         m_busy [2];
    logic [7:0] e_rd [2];
    logic       e_rv [2], e_err [2], e_busy [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int nb;
            nb = (k == 0) ? 16 : 12;
            e_rd[k] = 8'h00; e_rv[k] = 1'b0; e_err[k] = 1'b0;
            if (rst) begin
                m_busy[k] = 256;
            end else if (m_busy[k] > 0) begin
                m_busy[k]--;
                if (m_busy[k] == 0) begin
                    for (int b = 0; b < 16; b++)
                        for (int a = 0; a < 256; a++) m_mem[k][b][a] = 8'h00;
                end
            end else begin
                e_rv[k]  = re;
                e_rd[k]  = (re && int'(bank) < nb) ? m_mem[k][bank][addr] : 8'h00;
                e_err[k] = (int'(bank) >= nb) && (re || (we && !bc));
                if (we && bc) begin
                    for (int b = 0; b < nb; b++) m_mem[k][b][addr] = wd;
                end else if (we && int'(bank) < nb) begin
                    m_mem[k][bank][addr] = wd;
                end
            end
            e_busy[k] = (m_busy[k] > 0);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] b, input logic [7:0] a,
                         input logic [7:0] d, input logic w, input logic rr, input logic c);
        @(negedge Clk);
        rst = r; bank = b; addr = a; wd = d; we = w; re = rr; bc = c;
        @(posedge Clk);
        model_step();
        cyc++;
        #1;
        chk("model_rd_a",   32'(rd_a),   32'(e_rd[0]));
        chk("model_rv_a",   32'(rv_a),   32'(e_rv[0]));
        chk("model_err_a",  32'(err_a),  32'(e_err[0]));
        chk("model_busy_a", 32'(busy_a), 32'(e_busy[0]));
        chk("model_rd_b",   32'(rd_b),   32'(e_rd[1]));
        chk("model_rv_b",   32'(rv_b),   32'(e_rv[1]));
        chk("model_err_b",  32'(err_b),  32'(e_err[1]));
        chk("model_busy_b", 32'(busy_b), 32'(e_busy[1]));
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_req(input logic r);
        logic [7:0] a;
        a = ($urandom % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        drive(r, 4'($urandom_range(0, 15)), a, 8'($urandom), 1'($urandom),
              1'($urandom), ($urandom % 8 == 0));
    endtask

    // Busy must already be high from a preceding reset edge.
    task automatic busy_count(input string nm);
        int n;
        n = 0;
        while (busy_a && n < 400) begin
            idle();
            n++;
        end
        chk(nm, 32'(n), 32'd256);
    endtask

    typedef struct {
        logic [3:0] bank;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       we, re, bc;
        logic [7:0] rd_a;
        logic       rv;
        logic       err_a;
        logic [7:0] rd_b;
        logic       err_b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] b, input logic [7:0] a, input logic [7:0] d,
                                input logic w, input logic r, input logic c,
                                input logic [7:0] ra, input logic v, input logic ea,
                                input logic [7:0] rb, input logic eb);
        vec_t t;
        t.bank = b; t.addr = a; t.wd = d; t.we = w; t.re = r; t.bc = c;
        t.rd_a = ra; t.rv = v; t.err_a = ea; t.rd_b = rb; t.err_b = eb;
        return t;
    endfunction

    initial begin
        logic [3:0] cb [3];
        cb[0] = 4'd0; cb[1] = 4'd7; cb[2] = 4'd15;

        // Directed table; 12-bank copy expectations in the rd_b / err_b columns.
        foreach (cb[i]) begin
            vecs.push_back(mk(cb[i], 8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 0, 8'h00, cb[i] >= 12));
            vecs.push_back(mk(cb[i], 8'hFF, 8'h00, 0, 1, 0, 8'h00, 1, 0, 8'h00, cb[i] >= 12));
        end
        vecs.push_back(mk(4'd3, 8'h10, 8'hA5, 1, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(4'd3, 8'h10, 8'h00, 0, 1, 0, 8'hA5, 1, 0, 8'hA5, 0));
        vecs.push_back(mk(4'd4, 8'h10, 8'h00, 0, 1, 0, 8'h00, 1, 0, 8'h00, 0));
        vecs.push_back(mk(4'd3, 8'h10, 8'h3C, 1, 1, 0, 8'hA5, 1, 0, 8'hA5, 0));
        vecs.push_back(mk(4'd3, 8'h10, 8'h00, 0, 1, 0, 8'h3C, 1, 0, 8'h3C, 0));
        vecs.push_back(mk(4'd14, 8'h20, 8'h77, 1, 0, 1, 8'h00, 0, 0, 8'h00, 0));
        for (int b = 0; b < 16; b++)
            vecs.push_back(mk(4'(b), 8'h20, 8'h00, 0, 1, 0, 8'h77, 1, 0,
                              (b < 12) ? 8'h77 : 8'h00, b >= 12));
        vecs.push_back(mk(4'd13, 8'h05, 8'hFF, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(4'd13, 8'h05, 8'h00, 0, 1, 0, 8'hFF, 1, 0, 8'h00, 1));
        for (int b = 0; b < 12; b++)
            vecs.push_back(mk(4'(b), 8'h05, 8'h00, 0, 1, 0, 8'h00, 1, 0, 8'h00, 0));

        rst = 1'b1; bank = '0; addr = '0; wd = '0; we = 0; re = 0; bc = 0;
        m_busy[0] = 0; m_busy[1] = 0;

        // Reset state and full clear length.
        drive(1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset_busy", 32'(busy_a), 32'd1);
        chk("reset_rv",   32'(rv_a),   32'd0);
        chk("reset_rd",   32'(rd_a),   32'd0);
        busy_count("clear_busy_len");

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].bank, vecs[i].addr, vecs[i].wd,
                  vecs[i].we, vecs[i].re, vecs[i].bc);
            chk($sformatf("vec%0d_rd_a", i),  32'(rd_a),  32'(vecs[i].rd_a));
            chk($sformatf("vec%0d_rv_a", i),  32'(rv_a),  32'(vecs[i].rv));
            chk($sformatf("vec%0d_err_a", i), 32'(err_a), 32'(vecs[i].err_a));
            chk($sformatf("vec%0d_rd_b", i),  32'(rd_b),  32'(vecs[i].rd_b));
            chk($sformatf("vec%0d_rv_b", i),  32'(rv_b),  32'(vecs[i].rv));
            chk($sformatf("vec%0d_err_b", i), 32'(err_b), 32'(vecs[i].err_b));
        end

        // Reset at clear count 100 with requests ignored while busy.
        drive(1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) rand_req(1'b0);
        drive(1'b1, 4'h2, 8'h02, 8'h99, 1'b1, 1'b1, 1'b0);
        busy_count("rst_at_100_len");
        drive(1'b0, 4'h1, 8'h01, 8'h11, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'h1, 8'h01, 8'h22, 1'b1, 1'b1, 1'b0);
        busy_count("rst_after_wr_len");
        drive(1'b0, 4'h1, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("rst_wr_cleared_rd", 32'(rd_a), 32'h00);
        chk("rst_wr_cleared_rv", 32'(rv_a), 32'd1);

        for (int i = 0; i < 3000; i++) rand_req($urandom % 800 == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
